sig_run_ctrl: RTL and testbench

Sequencer for the signature-compaction datapath used to check the processor core (program sequencer plus instruction decoder). On `start` it holds the core in reset for a fixed number of cycles, then steps the 8-bit stimulus counter from 00 to FF. Each step folds a seeded probe word into a 16-bit rotate-add accumulator. At the end it freezes the signature and flags completion. The block sits between the core and the bench/top level, replacing free-running counter and accumulator logic with a restartable, self-terminating run.

---
 rtl/sig_run_ctrl.sv | 118 +++++++++++
 tb/tb_sig_run_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sig_run_ctrl.sv
// Restartable sequencer: holds the core in reset, sweeps the stimulus counter, and folds
// probe words into a rotate-add signature. Optional comparator enabled by SIG_COMPARE_EN.
module sig_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  seed,
  input  logic [7:0]  probe_word,
  input  logic [15:0] expected,
  output logic        dut_sync_reset,
  output logic [7:0]  stimulus,
  output logic [15:0] signature,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRstDut = 2'b01,
    StRun    = 2'b10,
    StDone   = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  stim_q, stim_d;
  logic [15:0] sig_q, sig_d;
  logic        pass_q, pass_d;
  logic        dsr_q, busy_q, done_q;
  logic [7:0]  sum;
  logic        sig_match;

  // 8-bit add, carry deliberately dropped
  assign sum = sig_q[7:0] + (probe_word ^ seed);

`ifdef SIG_COMPARE_EN
  assign sig_match = (sig_q == expected);
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign sig_match = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRstDut;
          cnt_d   = 4'(RST_CYCLES - 1);
          stim_d  = 8'h00;
          sig_d   = 16'h0000;
          pass_d  = 1'b0;
        end else if (state_q == StIdle) begin
          stim_d = 8'h00;
          sig_d  = 16'h0000;
        end
      end
      StRstDut: begin
        stim_d = 8'h00;
        sig_d  = 16'h0000;
        if (cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRun: begin
        if (stim_q != 8'hff) begin
          sig_d  = {sig_q[14:8], sum, sig_q[15]};
          stim_d = stim_q + 8'd1;
        end else begin
          state_d = StDone;
          pass_d  = sig_match;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      stim_q  <= 8'h00;
      sig_q   <= 16'h0000;
      pass_q  <= 1'b0;
      dsr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
      // Status flags registered from next state so they align with state_q
      dsr_q   <= (state_d == StRstDut);
      busy_q  <= (state_d == StRstDut) || (state_d == StRun);
      done_q  <= (state_d == StDone);
    end
  end

  assign dut_sync_reset = dsr_q;
  assign stimulus       = stim_q;
  assign signature      = sig_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_sig_run_ctrl.sv
// Self-checking bench for sig_run_ctrl: directed runs with random/patterned probe words
// checked cycle by cycle against an arithmetic signature model.
module tb_sig_run_ctrl;

  localparam int R = 4;
`ifdef SIG_COMPARE_EN
  localparam bit CmpEn = 1'b1;
`else
  localparam bit CmpEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  seed, probe_word;
  logic [15:0] expected;
  logic        dut_sync_reset, busy, done, pass;
  logic [7:0]  stimulus;
  logic [15:0] signature;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] trace_tbl [9] = '{16'h0002, 16'h0006, 16'h000e, 16'h001e, 16'h003e,
                                 16'h007e, 16'h00fe, 16'h01fe, 16'h03fe};

  sig_run_ctrl #(.RST_CYCLES(R)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .seed           (seed),
    .probe_word     (probe_word),
    .expected       (expected),
    .dut_sync_reset (dut_sync_reset),
    .stimulus       (stimulus),
    .signature      (signature),
    .busy           (busy),
    .done           (done),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One accumulation: keep bits 14..8, add word into low byte mod 256, wrap bit 15 to bit 0
  function automatic int model_step(input int sig, input int w);
    int hi7, lo, msb;
    hi7 = (sig / 256) % 128;
    lo  = (sig % 256 + w) % 256;
    msb = sig / 32768;
    return hi7 * 512 + lo * 2 + msb;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dsr"}, 16'(dut_sync_reset), 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
    chk({tag, "_done"}, 16'(done), 16'h0);
    chk({tag, "_pass"}, 16'(pass), 16'h0);
    chk({tag, "_stim"}, 16'(stimulus), 16'h0);
    chk({tag, "_sig"}, signature, 16'h0);
  endtask

  // mode 0: fixed probe, 1: random probe, 2: deterministic pattern per cycle
  task automatic run(input logic [7:0] sd, input int mode, input logic [7:0] fixed_p,
                     input bit hold, input bit abort, input logic [15:0] exp_sig,
                     input bit do_trace, output logic [15:0] sig_out);
    int msig, stim_exp, j;
    logic [7:0] p;
    msig     = 0;
    seed     = sd;
    expected = exp_sig;
    start    = 1'b1;
    sig_out  = 16'h0;
    for (int c = 0; c <= R + 256; c++) begin
      case (mode)
        0:       p = fixed_p;
        1:       p = 8'($urandom_range(0, 255));
        default: p = 8'((c * 37 + 11) % 256);
      endcase
      probe_word = p;
      if (c > 0) start = hold && (c < R + 256);
      @(posedge clk); #1;
      j = c - R;
      if (j >= 1 && j <= 255) msig = model_step(msig, int'(p ^ sd));
      stim_exp = (c < R) ? 0 : ((j > 255) ? 255 : j);
      chk("dsr", 16'(dut_sync_reset), 16'(c < R));
      chk("busy", 16'(busy), 16'(c < R + 256));
      chk("done", 16'(done), 16'(c == R + 256));
      chk("stim", 16'(stimulus), 16'(stim_exp));
      chk("sig", signature, 16'(msig));
      chk("pass", 16'(pass), 16'((c == R + 256) && CmpEn && (16'(msig) == exp_sig)));
      if (do_trace && j >= 1 && j <= 9) chk("trace", signature, trace_tbl[j-1]);
      if (abort && j == 8'h40) begin
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals("abort");
        return;
      end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      probe_word = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      chk("frz_done", 16'(done), 16'h1);
      chk("frz_busy", 16'(busy), 16'h0);
      chk("frz_stim", 16'(stimulus), 16'h00ff);
      chk("frz_sig", signature, 16'(msig));
    end
    sig_out = signature;
  endtask

  initial begin
    logic [15:0] s_a, s_b, s_c, s_d, s_tmp;
    reset      = 1'b1;
    start      = 1'b1;
    seed       = 8'h00;
    probe_word = 8'h00;
    expected   = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("idle");

    // Zero run
    run(8'h00, 0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, s_a);
    chk("zero_sig", s_a, 16'h0000);

    // Rotate-add trace, then compare runs
    run(8'h01, 0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b1, s_a);
    run(8'h01, 0, 8'h00, 1'b0, 1'b0, s_a, 1'b0, s_b);
    chk("cmp_repeat", s_b, s_a);
    run(8'h01, 0, 8'h00, 1'b0, 1'b0, s_a ^ 16'h0001, 1'b0, s_b);

    // Abort at stimulus 40, then a normal random run
    run(8'h5c, 1, 8'h00, 1'b0, 1'b1, 16'h0, 1'b0, s_tmp);
    run(8'h5c, 1, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, s_tmp);

    // Start held through RSTDUT/RUN, then restart from DONE
    run(8'h33, 2, 8'h00, 1'b1, 1'b0, 16'h0, 1'b0, s_a);
    run(8'h33, 2, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, s_b);
    chk("restart_same", s_b, s_a);

    // Seed switch
    run(8'haa, 2, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, s_a);
    run(8'h9a, 2, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, s_b);
    run(8'haa, 2, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, s_c);
    run(8'h9a, 2, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, s_d);
    chk("seed_aa_repro", s_c, s_a);
    chk("seed_9a_repro", s_d, s_b);
    chk("seed_differ", 16'(s_a != s_b), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
